toggle_rx: RTL

- Receive end of a toggle-signalling link: the transmitter flips one line (tog) once per event; this block recovers each flip as one queued event.
- Detects transitions on tog and counts pending events in a saturating queue counter.
- Presents pending events through a valid/ready handshake and keeps a wrap-around total count.
- Sits next to the toggling transmitter on the same clock; the transmitter clears its line to 0 on clr, and this block's reset state matches that.

---
 rtl/toggle_rx.sv | 107 ++++++++++
 1 files changed

// File: rtl/toggle_rx.sv
// Toggle-signalling receiver: each level change on tog becomes one queued event,
// drained through a valid/ready handshake. Define TOGGLE_RX_SYNC_EN for an extra input sync flop.
module toggle_rx #(
    parameter int PW = 4,
    parameter int TW = 8
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          tog,
    input  logic          evt_ready,
    input  logic          ovf_clr,
    output logic          evt_valid,
    output logic [PW-1:0] pend,
    output logic          full,
    output logic          ovf,
    output logic [TW-1:0] total
);

    localparam logic [PW-1:0] PMAX = {PW{1'b1}};
    localparam logic [PW-1:0] PONE = {{(PW-1){1'b0}}, 1'b1};

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] FULL = 2'd2;

    logic          tog_s;
    logic          tog_q;
    logic          det;
    logic          pop;
    logic          drop;
    logic [1:0]    state;
    logic [PW-1:0] pend_nxt;

    // Saturating step of the pending queue: simultaneous push and pop cancel.
    function automatic logic [PW-1:0] pend_step(input logic [PW-1:0] cur,
                                                 input logic up, input logic dn);
        if (up && !dn)
            return (cur == PMAX) ? cur : cur + PONE;
        else if (!up && dn)
            return cur - PONE;
        else
            return cur;
    endfunction

    function automatic logic [1:0] state_of(input logic [PW-1:0] p);
        if (p == '0)
            return IDLE;
        else if (p == PMAX)
            return FULL;
        else
            return BUSY;
    endfunction

`ifdef TOGGLE_RX_SYNC_EN
    logic tog_m;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            tog_m <= 1'b0;
            tog_s <= 1'b0;
            tog_q <= 1'b0;
        end else begin
            tog_m <= tog;
            tog_s <= tog_m;
            tog_q <= tog_s;
        end
    end
`else
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            tog_s <= 1'b0;
            tog_q <= 1'b0;
        end else begin
            tog_s <= tog;
            tog_q <= tog_s;
        end
    end
`endif

    // Detect stage: one-cycle pulse per level change seen on the sampled line.
    assign det      = tog_s ^ tog_q;
    assign pop      = evt_valid & evt_ready;
    assign drop     = det & full & ~pop;
    assign pend_nxt = pend_step(pend, det, pop);

    // Queue stage: pending count, state, totals and sticky overflow.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            pend  <= '0;
            state <= IDLE;
            total <= '0;
            ovf   <= 1'b0;
        end else begin
            pend  <= pend_nxt;
            state <= state_of(pend_nxt);
            total <= total + {{(TW-1){1'b0}}, det};
            if (drop)
                ovf <= 1'b1;
            else if (ovf_clr)
                ovf <= 1'b0;
        end
    end

    assign evt_valid = (state != IDLE);
    assign full      = (state == FULL);

endmodule
